// File: rtl/rpc_reg_init_seq.sv
// Boot-time register-write sequencer: 1-cycle start latency, 2 cycles/entry (4 with RPC_INIT_READBACK_EN).
// Holds each request until reg_ready_i or timeout; failed attempts are retried after a one-cycle gap.
module rpc_reg_init_seq #(
    parameter int unsigned REG_ADDR_WIDTH = 48,
    parameter int unsigned REG_DATA_WIDTH = 32,
    parameter int unsigned NumEntries     = 8,
    parameter int unsigned MaxRetries     = 3,
    parameter int unsigned TimeoutCycles  = 1024,
    parameter logic [NumEntries-1:0][REG_ADDR_WIDTH-1:0] InitAddr = '0,
    parameter logic [NumEntries-1:0][REG_DATA_WIDTH-1:0] InitData = '0,
    parameter logic [NumEntries-1:0][REG_DATA_WIDTH-1:0] InitMask = '1,
    localparam int unsigned IdxW = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic [IdxW-1:0]             err_idx_o,
    output logic [REG_ADDR_WIDTH-1:0]   reg_addr_o,
    output logic                        reg_write_o,
    output logic [REG_DATA_WIDTH-1:0]   reg_wdata_o,
    output logic [REG_DATA_WIDTH/8-1:0] reg_wstrb_o,
    output logic                        reg_valid_o,
    input  logic [REG_DATA_WIDTH-1:0]   reg_rdata_i,
    input  logic                        reg_ready_i,
    input  logic                        reg_error_i
);

    localparam int unsigned RetryW = $clog2(MaxRetries + 1);
    localparam int unsigned TmoW   = $clog2(TimeoutCycles);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_GAP,
`ifdef RPC_INIT_READBACK_EN
        S_READ,
`endif
        S_DONE,
        S_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [TmoW-1:0]   tcnt_q, tcnt_d;
    logic              xfer_st;
    logic              rd_ok;
    logic              last_entry;
    logic              xfer_ok;
    logic              xfer_fail;

`ifdef RPC_INIT_READBACK_EN
    logic rd_pend_q, rd_pend_d;

    assign xfer_st = (state_q == S_WRITE) || (state_q == S_READ);
    // Writes always pass this qualifier; reads compare only the masked bits.
    assign rd_ok   = (state_q == S_WRITE) ||
                     ((reg_rdata_i & InitMask[idx_q]) == (InitData[idx_q] & InitMask[idx_q]));
`else
    logic unused_rdata;

    assign xfer_st      = (state_q == S_WRITE);
    assign rd_ok        = 1'b1;
    assign unused_rdata = ^{reg_rdata_i, InitMask};
`endif

    assign last_entry = (idx_q == IdxW'(NumEntries - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            retry_q   <= '0;
            tcnt_q    <= '0;
`ifdef RPC_INIT_READBACK_EN
            rd_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            tcnt_q    <= tcnt_d;
`ifdef RPC_INIT_READBACK_EN
            rd_pend_q <= rd_pend_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        tcnt_d    = tcnt_q;
        xfer_ok   = 1'b0;
        xfer_fail = 1'b0;
`ifdef RPC_INIT_READBACK_EN
        rd_pend_d = rd_pend_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start_i) begin
                    state_d = S_WRITE;
                    idx_d   = '0;
                    retry_d = '0;
`ifdef RPC_INIT_READBACK_EN
                    rd_pend_d = 1'b0;
`endif
                end
            end
            S_GAP: begin
`ifdef RPC_INIT_READBACK_EN
                state_d = rd_pend_q ? S_READ : S_WRITE;
`else
                state_d = S_WRITE;
`endif
            end
            default: ;
        endcase

        if (xfer_st) begin
            // A completing handshake takes priority over an expiring timeout.
            if (reg_ready_i) begin
                if (!reg_error_i && rd_ok) xfer_ok = 1'b1;
                else                       xfer_fail = 1'b1;
            end else if (tcnt_q == TmoW'(TimeoutCycles - 1)) begin
                xfer_fail = 1'b1;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end

            if (xfer_ok) begin
`ifdef RPC_INIT_READBACK_EN
                if (state_q == S_WRITE) begin
                    state_d   = S_GAP;
                    rd_pend_d = 1'b1;
                end else begin
                    rd_pend_d = 1'b0;
`endif
                    if (last_entry) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        retry_d = '0;
                        state_d = S_GAP;
                    end
`ifdef RPC_INIT_READBACK_EN
                end
`endif
            end else if (xfer_fail) begin
`ifdef RPC_INIT_READBACK_EN
                rd_pend_d = 1'b0;
`endif
                if (int'(retry_q) + 1 == int'(MaxRetries)) begin
                    state_d = S_FAIL;
                end else begin
                    retry_d = retry_q + 1'b1;
                    state_d = S_GAP;
                end
            end
        end

        if (state_d != state_q) tcnt_d = '0;

        reg_valid_o = 1'b0;
        reg_write_o = 1'b0;
        reg_addr_o  = '0;
        reg_wdata_o = '0;
        reg_wstrb_o = '0;
        case (state_q)
            S_WRITE: begin
                reg_valid_o = 1'b1;
                reg_write_o = 1'b1;
                reg_addr_o  = InitAddr[idx_q];
                reg_wdata_o = InitData[idx_q];
                reg_wstrb_o = '1;
            end
`ifdef RPC_INIT_READBACK_EN
            S_READ: begin
                reg_valid_o = 1'b1;
                reg_addr_o  = InitAddr[idx_q];
            end
`endif
            default: ;
        endcase

        busy_o    = xfer_st || (state_q == S_GAP);
        done_o    = (state_q == S_DONE);
        error_o   = (state_q == S_FAIL);
        err_idx_o = (state_q == S_FAIL) ? idx_q : '0;
    end

endmodule
